// File: rtl/uncached_storer_pkg.sv
// Shared AXI constants for the uncached load/store path: IDs, FSM encodings,
// size and response codes, plus the storer's debug view.
package uncached_storer_pkg;

   // AXI write/read IDs owned by the uncached path
   localparam logic [3:0] STORER_AXI_ID = 4'b0011;
   localparam logic [3:0] LOADER_AXI_ID = 4'b0010;

   // Uncached storer FSM encodings
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_REQ  = 3'd1;
   localparam logic [2:0] ST_ADDR = 3'd2;
   localparam logic [2:0] ST_RESP = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   // Uncached loader FSM encodings
   localparam logic [2:0] LD_IDLE = 3'd0;
   localparam logic [2:0] LD_REQ  = 3'd1;
   localparam logic [2:0] LD_ADDR = 3'd2;
   localparam logic [2:0] LD_DATA = 3'd3;
   localparam logic [2:0] LD_DONE = 3'd4;

   // AXI transfer size codes (bytes = 1 << size)
   localparam logic [2:0] AXI_SIZE_BYTE = 3'd0;
   localparam logic [2:0] AXI_SIZE_HALF = 3'd1;
   localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef struct packed {
      logic [2:0] state;
      logic       awPending;
      logic       wPending;
      logic       bPending;
   } storer_dbg_t;

   // A store only starts for an uncached, enabled access touching at least one lane
   function automatic logic storeStart(input logic uncached, input logic we,
                                       input logic [3:0] wsel);
      return uncached & we & (wsel != 4'b0000);
   endfunction

endpackage

// File: rtl/uncached_storer_if.sv
// Arbiter-side bus of the uncached storer: request/grant plus AXI AW, W and B.
// Handshake: a beat transfers on a rising clk edge where valid & ready are both
// high; valid, once raised, stays high with stable payload until that edge.
interface uncached_storer_if;
   logic        req;
   logic        grnt;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [2:0]  awsize;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output req, awid, awaddr, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
      input  grnt, awready, wready, bid, bresp, bvalid
   );

   modport slave (
      input  req, awid, awaddr, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
      output grnt, awready, wready, bid, bresp, bvalid
   );
endinterface

// File: rtl/uncached_storer_size_decode.sv
// Maps a byte-lane select to an AXI size code and the aligned low address bits.
module uncached_size_decode
   import uncached_storer_pkg::*;
(
   input  logic [3:0] wsel,
   input  logic [1:0] addrLo,
   output logic [2:0] awsize,
   output logic [1:0] awaddrLo
);

   always_comb begin
      awsize = AXI_SIZE_WORD;
      case (wsel)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: awsize = AXI_SIZE_BYTE;
         4'b0011, 4'b1100:                   awsize = AXI_SIZE_HALF;
         default:                            awsize = AXI_SIZE_WORD;
      endcase
   end

   // Odd lane patterns go out as a full word; wstrb still masks the bytes
   always_comb begin
      awaddrLo = 2'b00;
      case (awsize)
         AXI_SIZE_BYTE: awaddrLo = addrLo;
         AXI_SIZE_HALF: awaddrLo = {addrLo[1], 1'b0};
         default:       awaddrLo = 2'b00;
      endcase
   end

endmodule

// File: rtl/uncached_storer.sv
// Single-beat AXI write engine for uncached CPU stores: latches the store,
// requests the bus, issues AW and W independently, then waits for its B response.
module uncached_storer
   import uncached_storer_pkg::*;
#(
   parameter logic [3:0] AXI_ID = STORER_AXI_ID
)(
   input  logic                clk,
   input  logic                rst,
   uncached_storer_if.master   bus,
   input  logic                cpu_uncached,
   input  logic                cpu_we,
   input  logic [31:0]         cpu_addr,
   input  logic [31:0]         cpu_wdata,
   input  logic [3:0]          cpu_wsel,
   output logic                cpu_Stall,
   output logic                bus_err,
   output storer_dbg_t         dbg
);

   logic [2:0]  state;
   logic [31:0] addrQ;
   logic [31:0] dataQ;
   logic [3:0]  wselQ;
   logic        reqQ;
   logic        awvalidQ;
   logic        wvalidQ;
   logic        breadyQ;
   logic        busErrQ;

   logic        start;
   logic        awFire;
   logic        wFire;
   logic        awDone;
   logic        wDone;
   logic        bHit;
   logic [2:0]  awsizeDec;
   logic [1:0]  awaddrLoDec;

   assign start  = storeStart(cpu_uncached, cpu_we, cpu_wsel);
   assign awFire = awvalidQ & bus.awready;
   assign wFire  = wvalidQ & bus.wready;
   // A channel is finished once its valid has dropped or it handshakes this cycle
   assign awDone = ~awvalidQ | bus.awready;
   assign wDone  = ~wvalidQ | bus.wready;
   assign bHit   = bus.bvalid & (bus.bid == AXI_ID);

   uncached_size_decode uSizeDecode (
      .wsel     (wselQ),
      .addrLo   (addrQ[1:0]),
      .awsize   (awsizeDec),
      .awaddrLo (awaddrLoDec)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         addrQ    <= 32'd0;
         dataQ    <= 32'd0;
         wselQ    <= 4'd0;
         reqQ     <= 1'b0;
         awvalidQ <= 1'b0;
         wvalidQ  <= 1'b0;
         breadyQ  <= 1'b0;
         busErrQ  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               awvalidQ <= 1'b0;
               wvalidQ  <= 1'b0;
               breadyQ  <= 1'b0;
               if (start) begin
                  addrQ <= cpu_addr;
                  dataQ <= cpu_wdata;
                  wselQ <= cpu_wsel;
                  reqQ  <= 1'b1;
                  state <= ST_REQ;
               end else begin
                  reqQ <= 1'b0;
               end
            end
            ST_REQ: begin
               if (bus.grnt) begin
                  awvalidQ <= 1'b1;
                  wvalidQ  <= 1'b1;
                  state    <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (awFire) awvalidQ <= 1'b0;
               if (wFire)  wvalidQ  <= 1'b0;
               if (awDone && wDone) begin
                  breadyQ <= 1'b1;
                  state   <= ST_RESP;
               end
            end
            ST_RESP: begin
               // Responses carrying another master's ID are not ours to consume
               if (bHit) begin
                  breadyQ <= 1'b0;
                  busErrQ <= (bus.bresp != AXI_RESP_OKAY);
                  state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               reqQ    <= 1'b0;
               busErrQ <= 1'b0;
               state   <= ST_IDLE;
            end
            default: begin
               reqQ     <= 1'b0;
               awvalidQ <= 1'b0;
               wvalidQ  <= 1'b0;
               breadyQ  <= 1'b0;
               busErrQ  <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

   // The IDLE term lets the pipeline freeze in the same cycle the store appears
   assign cpu_Stall = ((state == ST_IDLE) & start) |
                      (state == ST_REQ) | (state == ST_ADDR) | (state == ST_RESP);
   assign bus_err   = busErrQ;

   assign bus.req     = reqQ;
   assign bus.awid    = AXI_ID;
   assign bus.awaddr  = {addrQ[31:2], awaddrLoDec};
   assign bus.awsize  = awsizeDec;
   assign bus.awvalid = awvalidQ;
   assign bus.wdata   = dataQ;
   assign bus.wstrb   = wselQ;
   assign bus.wlast   = 1'b1;
   assign bus.wvalid  = wvalidQ;
   assign bus.bready  = breadyQ;

   assign dbg.state     = state;
   assign dbg.awPending = awvalidQ;
   assign dbg.wPending  = wvalidQ;
   assign dbg.bPending  = breadyQ;

endmodule

// File: doc/uncached_storer.md
UNCACHED_STORER -- requirements
Module: uncached_storer

Interface
REQ-001 The block SHALL take parameter AXI_ID, default 4'b0011, the AXI write ID used on awid and expected on bid.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  output  1  bus request to the AXI arbiter.
REQ-005 grnt  input  1  arbiter grant.
REQ-006 awid  output  4  constant AXI_ID.
REQ-007 awaddr  output  32  write address.
REQ-008 awsize  output  3  transfer size.
REQ-009 awvalid  output  1  AW valid.
REQ-010 awready  input  1  AW ready.
REQ-011 wdata  output  32  write data.
REQ-012 wstrb  output  4  byte strobes.
REQ-013 wlast  output  1  constant 1; single-beat writes only.
REQ-014 wvalid  output  1  W valid.
REQ-015 wready  input  1  W ready.
REQ-016 bid  input  4  response ID.
REQ-017 bresp  input  2  response code.
REQ-018 bvalid  input  1  B valid.
REQ-019 bready  output  1  B ready.
REQ-020 cpu_uncached  input  1  access targets uncached space.
REQ-021 cpu_we  input  1  CPU store enable.
REQ-022 cpu_addr  input  32  byte address.
REQ-023 cpu_wdata  input  32  store data, lane-aligned.
REQ-024 cpu_wsel  input  4  byte-lane select.
REQ-025 cpu_Stall  output  1  pipeline stall, also used as PC stall.
REQ-026 bus_err  output  1  one-cycle pulse on a non-OKAY write response.
REQ-027 awlen, awburst, awlock, awcache, awprot and wid SHALL NOT be ports; the arbiter wrapper ties them (awlen 0, awburst 0, wid = awid).

Function
REQ-028 start SHALL be cpu_uncached & cpu_we & (cpu_wsel != 0); a zero wsel SHALL never start a transaction.
REQ-029 The FSM SHALL have the states IDLE, REQ, ADDR, RESP and DONE.
REQ-030 IDLE with start: the block SHALL latch cpu_addr, cpu_wdata and cpu_wsel, set req to 1 and go to REQ. Otherwise it SHALL stay in IDLE with req, awvalid, wvalid and bready at 0.
REQ-031 REQ: grnt SHALL be sampled only in this state. On grnt the block SHALL go to ADDR with awvalid and wvalid both set to 1. Otherwise it SHALL hold.
REQ-032 ADDR: awvalid SHALL clear in the cycle after an awvalid&awready handshake. wvalid SHALL clear in the cycle after a wvalid&wready handshake. The two channels are independent, in either order or in the same cycle. Once both handshakes are done the block SHALL go to RESP with bready set to 1.
REQ-033 RESP: on bvalid & (bid == AXI_ID) the block SHALL go to DONE, clear bready, and set bus_err to (bresp != 0). A bvalid with any other bid SHALL be ignored.
REQ-034 DONE: the block SHALL clear req and bus_err and go to IDLE unconditionally.
REQ-035 cpu_Stall SHALL be (state == IDLE & start) | state in {REQ, ADDR, RESP}, combinational; it SHALL be 0 in DONE.
REQ-036 awsize from latched wsel: one-hot selects SHALL give 0; 0011 or 1100 SHALL give 1; every other value SHALL give 2.
REQ-037 awaddr SHALL be latched addr[31:2] followed by: addr[1:0] for size 0, {addr[1],0} for size 1, 00 for size 2.
REQ-038 wstrb and wdata SHALL be the latched values. CPU input changes after the latch SHALL be ignored.
REQ-039 Minimum latency, with grnt, awready, wready and bvalid all immediate: cpu_Stall SHALL be high for exactly 4 cycles (IDLE, REQ, ADDR, RESP), then low in DONE.
REQ-040 A new store presented in the IDLE cycle after DONE SHALL start normally.

Reset
REQ-041 While rst is high: state IDLE; req, awvalid, wvalid, bready and bus_err 0; latched address, data and strobe registers 0.
REQ-042 Reset mid-transaction SHALL abandon the transaction with no pending-response tracking; the interconnect is reset together with this block.

Structure
REQ-043 The FSM state encodings, the AXI size codes and the default AXI_ID SHALL be in the shared AXI package, alongside the uncached loader's constants.
REQ-044 The block SHALL be one module plus one combinational sub-module, uncached_size_decode (wsel, addr[1:0] -> awsize, awaddr[1:0]).

Verification
REQ-045 Bench: sw to 0x1FAF0000, data 0xDEADBEEF, wsel 1111, all handshakes immediate -> awaddr 0x1FAF0000, awsize 2, wstrb F, cpu_Stall high for 4 cycles, bus_err 0.
REQ-046 Bench: sb to 0x1FAF0003, wsel 1000 -> awsize 0, awaddr 0x1FAF0003, wstrb 8.
REQ-047 Bench: wready immediate, awready delayed 3 cycles -> wvalid drops first, awvalid held 4 cycles, RESP entered after the AW handshake.
REQ-048 Bench: in RESP, bvalid with bid 0010 then bvalid with bid 0011 and bresp 10 -> first ignored; DONE follows the second; bus_err high for exactly 1 cycle.
REQ-049 Bench: grnt held low 5 cycles -> req high, awvalid and wvalid low, cpu_Stall high throughout.
REQ-050 Bench: rst pulsed while in RESP -> all outputs 0 immediately, state IDLE; the next store completes normally.
